// File: rtl/midi_pkg.sv
// Shared MIDI definitions: line rate, oversampling factor and receiver states.
package midi_pkg;

    localparam int MIDI_BAUD  = 31250;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/midi_baud_tick.sv
// Oversample tick generator: one-cycle pulse every TICK_DIV clocks.
// Holding clear pins the counter at 0 so the tick phase can be aligned to an
// external event (start-bit detection on the receive side).
module midi_baud_tick
    import midi_pkg::*;
#(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at TICK_DIV-1, held at zero while cleared.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI IN receiver (31250 baud, 8N1, idle high) with a single-entry holding
// register and valid/ready handshake toward the message parser.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, tick generator held, waiting for rxs low
// ST_START | timing to the start-bit mid point, glitch rejection there
// ST_DATA  | sampling 8 data bits at bit centres, LSB first
// ST_STOP  | sampling the stop bit; good byte or framing error
// ST_BREAK | stop bit was low; wait for the line to return high
module midi_uart_rx #(
    parameter int TICK_DIV   = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    import midi_pkg::*;

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);

    rx_state_e         state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              meta_q, meta_d;
    logic              rxs_q, rxs_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic tick;
    logic tick_clear;
    logic byte_done;
    logic stop_bad;
    logic accept;

    assign tick_clear = (state_q == ST_IDLE);

    midi_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Two-flop synchronizer on the raw MIDI IN pin.
    always_comb begin
        meta_d = rxd;
        rxs_d  = meta_q;
    end

    // Receive FSM: bit-centre sampling driven by the oversample tick.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                scnt_d = '0;
                bcnt_d = '0;
                if (!rxs_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (scnt_q == HALF_LAST) begin
                        scnt_d  = '0;
                        state_d = rxs_q ? ST_IDLE : ST_DATA;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (scnt_q == FULL_LAST) begin
                        scnt_d  = '0;
                        shift_d = {rxs_q, shift_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            bcnt_d  = '0;
                            state_d = ST_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (scnt_q == FULL_LAST) begin
                        scnt_d = '0;
                        if (rxs_q) begin
                            byte_done = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = ST_BREAK;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register and flags; a byte accepted this cycle frees the slot
    // for a byte completing in the same cycle.
    always_comb begin
        accept      = rx_valid_q & rx_ready;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;
        if (accept) begin
            rx_valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!rx_valid_q || accept) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // All state registers, synchronous active-low reset; synchronizer resets to idle-high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            meta_q      <= 1'b1;
            rxs_q       <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            meta_q      <= meta_d;
            rxs_q       <= rxs_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at TICK_DIV=4 (64 clocks per bit) with a
// frame-level model: each frame sent decides up front whether the consumer
// should see the byte, an overrun, or a framing error.
module tb_midi_uart_rx;

    localparam int TD       = 4;
    localparam int BIT_CLKS = 16 * TD;
    localparam int LAT_NOM  = 2 + (19 * 16 * TD) / 2;
    localparam int LAT_LO   = LAT_NOM - TD;
    localparam int LAT_HI   = LAT_NOM + TD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    midi_uart_rx #(
        .TICK_DIV   (TD),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         ferr_seen = 0;
    int         ovr_seen = 0;
    int         valid_hi = 0;
    int         cyc = 0;
    int         rise_cyc = -1;
    int         frame_start_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_rx = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of the holding register against the model queue.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                valid_hi++;
                if (!prev_valid) rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_valid: rx_valid=1 rx_data=%02h, model holds no byte (t=%0t)",
                             rx_data, $time);
                end else begin
                    chk("rx_data_vs_model", {24'b0, rx_data}, {24'b0, exp_q[0]});
                    if (rx_ready) begin
                        last_rx = rx_data;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (frame_err || overrun) chk("flag_exclusive", {31'b0, frame_err & overrun}, 32'd0);
        end
        prev_valid = rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (exp_q.size() != 0 && !rx_ready) exp_ovr++;
            else exp_q.push_back(b);
        end else begin
            exp_ferr++;
        end
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_frame_err_count"}, ferr_seen, exp_ferr);
        chk({tag, "_overrun_count"}, ovr_seen, exp_ovr);
        chk({tag, "_model_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int ovr0;
        int ferr0;
        logic [7:0] aa;

        // Reset held low while the line toggles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 rxd = ~rxd;
            @(negedge clk);
            chk("reset_outputs", {20'b0, rx_data, rx_valid, frame_err, overrun, busy}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        rxd   = 1'b1;
        idle(8);
        chk("busy_after_reset", {31'b0, busy}, 32'd0);

        // Clean 0x90 with the consumer always ready.
        valid_hi = 0;
        rise_cyc = -1;
        send_frame(8'h90, 1'b1);
        idle(BIT_CLKS);
        lat = rise_cyc - frame_start_cyc;
        vectors++;
        if (rise_cyc < 0 || lat < LAT_LO || lat > LAT_HI) begin
            miscompares++;
            $display("FAIL latency_0x90: got %0d clocks, expected %0d..%0d", lat, LAT_LO, LAT_HI);
        end
        chk("valid_width_0x90", valid_hi, 1);
        chk("data_0x90", {24'b0, last_rx}, 32'h90);
        check_counts("t90");

        // Back-to-back 0x3C, 0x7F with no accept: second byte overruns.
        rx_ready = 1'b0;
        ovr0 = ovr_seen;
        send_frame(8'h3C, 1'b1);
        send_frame(8'h7F, 1'b1);
        idle(BIT_CLKS);
        chk("hold_0x3C", {24'b0, rx_data}, 32'h3C);
        chk("valid_held", {31'b0, rx_valid}, 32'd1);
        chk("overrun_once", ovr_seen - ovr0, 1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("valid_fall_after_ready", {31'b0, rx_valid}, 32'd0);
        chk("accepted_0x3C", {24'b0, last_rx}, 32'h3C);
        idle(4);
        check_counts("ovr");

        // 0x45 with a low stop bit followed by a held break, then 0xF8.
        ferr0 = ferr_seen;
        send_frame(8'h45, 1'b0);
        rxd = 1'b0;
        idle(3 * BIT_CLKS);
        chk("break_busy", {31'b0, busy}, 32'd1);
        rxd = 1'b1;
        idle(2 * BIT_CLKS);
        chk("frame_err_once", ferr_seen - ferr0, 1);
        send_frame(8'hF8, 1'b1);
        idle(BIT_CLKS);
        chk("data_0xF8", {24'b0, last_rx}, 32'hF8);
        check_counts("ferr");

        // 20-clock glitch on the idle line.
        rxd = 1'b0;
        idle(10);
        chk("glitch_busy_rise", {31'b0, busy}, 32'd1);
        idle(10);
        rxd = 1'b1;
        idle(30);
        chk("glitch_busy_fall", {31'b0, busy}, 32'd0);
        idle(BIT_CLKS);
        check_counts("glitch");

        // Reset during bit 4 of 0xAA, held until the frame has passed.
        aa = 8'hAA;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(aa[i]);
        rxd = aa[4];
        idle(20);
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        idle(2);
        chk("midframe_reset_outputs", {20'b0, rx_data, rx_valid, frame_err, overrun, busy}, 32'd0);
        idle(BIT_CLKS - 22);
        for (int i = 5; i < 8; i++) drive_bit(aa[i]);
        drive_bit(1'b1);
        reset = 1'b1;
        idle(BIT_CLKS);
        chk("post_reset_idle", {31'b0, busy}, 32'd0);
        send_frame(8'h55, 1'b1);
        idle(BIT_CLKS);
        chk("data_0x55", {24'b0, last_rx}, 32'h55);
        check_counts("rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
- MIDI serial receiver: 31250 baud, 8N1, idle-high line.
- Runs from the master clock and is held in reset by the master reset generator, which sits directly upstream.
- Recovers bytes from the MIDI IN pin and presents them to the router's message parser through a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- TICK_DIV, default 16: clk cycles per oversample tick. Tick rate is 16 × 31250 Hz, so the default assumes an 8 MHz clk. Legal range is 2 or more.
- OVERSAMPLE, default 16: ticks per bit. Fixed; the block is not verified at other values.

Ports:
- clk, input, 1: system clock. All logic on its rising edge.
- reset, input, 1: synchronous, active-low. 0 = reset.
- rxd, input, 1: raw asynchronous MIDI IN line. Idle = 1.
- rx_data, output, 8: received byte, LSB is the first data bit.
- rx_valid, output, 1: rx_data holds an unconsumed byte.
- rx_ready, input, 1: consumer accepts the byte in the current cycle.
- frame_err, output, 1: one-cycle pulse when a stop bit is sampled 0.
- overrun, output, 1: one-cycle pulse when a good byte is dropped because the holding register is full.
- busy, output, 1: high in every FSM state except IDLE.

Behaviour:
- Reset (reset=0 at a clk edge):
  - FSM goes to IDLE; tick, bit and sample counters clear.
  - Both synchronizer flops are set to 1.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the partial byte. No flag is raised.
- Synchronizer: 2 flops on rxd. All decisions use the synchronized value rxs (2-cycle input latency).
- Tick generator: counts 0..TICK_DIV-1 and emits a one-cycle tick at the wrap. It is held at 0 while in IDLE, so phase is aligned to start-bit detection.
- FSM:
  - IDLE: rxs=0 → START with sample count 0.
  - START: on tick 8 (mid start bit), rxs=0 → DATA; rxs=1 → IDLE as a glitch reject, no flag.
  - DATA: sample rxs every 16 ticks after the start-bit mid point. Shift right into the shift register, LSB first. After bit 7 → STOP.
  - STOP: sample at mid stop bit.
    - rxs=1: byte complete, → IDLE. The next start edge can be detected immediately, so there is no half-bit dead time.
    - rxs=0: frame_err pulses, the byte is discarded, → BREAK.
  - BREAK: wait for rxs=1, then → IDLE. A held-low break produces exactly one frame_err.
- Output handshake:
  - A completed byte loads rx_data and sets rx_valid on the clk edge following the stop sample.
  - rx_valid=1 and rx_ready=1 clears rx_valid on the next edge.
  - rx_data is stable while rx_valid=1.
  - Completion while rx_valid=1 and rx_ready=0: the new byte is dropped, overrun pulses, and the old byte stays.
  - Completion in the same cycle as rx_valid & rx_ready: the new byte loads and rx_valid stays 1. No overrun.
- rx_ready is ignored while rx_valid=0.
- frame_err and overrun are never asserted in the same cycle.
- Latency: the rxd falling edge at the start bit to rx_valid rise is 2 + 9.5×16×TICK_DIV clocks, ±TICK_DIV.

Decomposition:
- Shared package midi_pkg:
  - constants MIDI_BAUD=31250 and OVERSAMPLE=16.
  - rx state enumeration: IDLE, START, DATA, STOP, BREAK (3-bit).
- Sub-module midi_baud_tick: parameter TICK_DIV; inputs clk, reset, clear; output tick.
  - Reusable by the planned midi_uart_tx.

Test Plan (TICK_DIV=4, so 64 clk per bit):
- Reset held low 5 cycles while rxd toggles → all outputs 0 throughout. After release with rxd=1, busy=0.
- Send 0x90 as a clean 8N1 frame, rx_ready=1 → rx_valid pulses for 1 cycle with rx_data=0x90. frame_err=0, overrun=0.
- Send 0x3C then 0x7F back-to-back with rx_ready=0 and no accept in between → rx_data stays 0x3C and overrun pulses once at the second stop sample. Assert rx_ready, then rx_valid falls on the next edge.
- Send 0x45 with the stop bit forced 0, then hold rxd low for 3 bit times → one frame_err pulse and no rx_valid. After rxd returns high, a following 0xF8 is received correctly.
- 20-clk low glitch on idle rxd → busy rises then returns to 0 by the start-bit mid point. No rx_valid, no flags.
- Assert reset low during bit 4 of a 0xAA frame → outputs clear. The frame tail is not reported. A subsequent 0x55 is received correctly.
